// File: rtl/sc_edge_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : sc_edge_sequencer
//  Description : Drives deterministic unary bitstreams for one 2x2 pixel
//                window into the stochastic Roberts-cross detector, counts
//                the detector's ones over one stream period and returns the
//                saturated count as the edge magnitude (valid/ready).
//  Revision    : 1.0 - initial release
// ============================================================================
module sc_edge_sequencer #(
    parameter int W   = 8,
    parameter int LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] p00,
    input  logic [W-1:0] p01,
    input  logic [W-1:0] p10,
    input  logic [W-1:0] p11,
    output logic         sc_r00,
    output logic         sc_r01,
    output logic         sc_r10,
    output logic         sc_r11,
    output logic         sc_sel,
    input  logic         sc_s,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_pix,
    output logic         busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Last drain-counter value; unused when the detector is combinational.
    localparam logic [1:0] c_dlast = 2'((LAT > 0) ? (LAT - 1) : 0);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [W-1:0]   r_p00, r_p01, r_p10, r_p11;
    logic [W-1:0]   r_c;
    logic [W:0]     r_cnt;
    logic [W:0]     w_cnt_nxt;
    logic [1:0]     r_dc;
    logic [W-1:0]   r_out_pix;
    logic [W-1:0]   w_pix_sat;
    logic           w_run;
    logic           w_last;
    logic           w_vld_d;
    logic           w_inc;

    assign w_run  = (r_state == S_RUN);
    assign w_last = (r_c == {W{1'b1}});

    // Sample-valid flag delayed to line up with the detector output.
    generate
        if (LAT == 0) begin : g_nodly
            assign w_vld_d = w_run;
        end else begin : g_dly
            logic [LAT-1:0] r_dly;
            // Shift the RUN flag through a LAT-deep delay line.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_dly <= '0;
                end else begin
                    r_dly <= LAT'({r_dly, w_run});
                end
            end
            assign w_vld_d = r_dly[LAT-1];
        end
    endgenerate

    assign w_inc     = w_vld_d & sc_s;
    assign w_cnt_nxt = r_cnt + {{W{1'b0}}, w_inc};
    // A full period of ones gives 2^W, one past what out_pix can hold.
    assign w_pix_sat = w_cnt_nxt[W] ? {W{1'b1}} : w_cnt_nxt[W-1:0];
    assign out_pix   = r_out_pix;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        sc_r00      = 1'b0;
        sc_r01      = 1'b0;
        sc_r10      = 1'b0;
        sc_r11      = 1'b0;
        sc_sel      = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // Shared phase counter keeps the four streams fully correlated.
                sc_r00 = (r_p00 > r_c);
                sc_r01 = (r_p01 > r_c);
                sc_r10 = (r_p10 > r_c);
                sc_r11 = (r_p11 > r_c);
                sc_sel = r_c[0];
                if (w_last) begin
                    w_state_nxt = (LAT > 0) ? S_DRAIN : S_DONE;
                end
            end
            S_DRAIN: begin
                if (r_dc == c_dlast) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Window capture, phase/ones counting and result registration.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_p00     <= '0;
            r_p01     <= '0;
            r_p10     <= '0;
            r_p11     <= '0;
            r_c       <= '0;
            r_cnt     <= '0;
            r_dc      <= '0;
            r_out_pix <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_p00 <= p00;
                        r_p01 <= p01;
                        r_p10 <= p10;
                        r_p11 <= p11;
                        r_c   <= '0;
                        r_cnt <= '0;
                    end
                end
                S_RUN: begin
                    r_c   <= r_c + 1'b1;
                    r_cnt <= w_cnt_nxt;
                    r_dc  <= '0;
                end
                S_DRAIN: begin
                    r_dc  <= r_dc + 1'b1;
                    r_cnt <= w_cnt_nxt;
                end
                default: begin
                end
            endcase
            // Final sample lands on the same edge as DONE entry.
            if ((r_state != S_DONE) && (w_state_nxt == S_DONE)) begin
                r_out_pix <= w_pix_sat;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sc_edge_sequencer.sv
`timescale 1ns/1ps
module tb_sc_edge_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_valid2, in_ready, in_ready2;
    logic [7:0] p00, p01, p10, p11;
    logic       sc_r00, sc_r01, sc_r10, sc_r11, sc_sel, sc_s;
    logic       t_r00, t_r01, t_r10, t_r11, t_sel, sc_s2;
    logic       out_valid, out_ready, out_valid2, out_ready2;
    logic [7:0] out_pix, out_pix2;
    logic       busy, busy2;

    typedef struct {int a; int b; int c; int d; int mode; int exp;} vec_t;
    typedef struct {int pix; int cyc;} sb_t;

    sb_t  q[$];
    sb_t  q2[$];
    sb_t  e1, e2s;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   mode   = 0;
    int   mode2  = 0;
    logic f1 = 1'b0, f2 = 1'b0, d1 = 1'b0, g1 = 1'b0, g2 = 1'b0;
    logic ov_prev = 1'b0, ov2_prev = 1'b0;

    always #5 clk = ~clk;

    sc_edge_sequencer #(.W(8), .LAT(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .p00(p00), .p01(p01), .p10(p10), .p11(p11),
        .sc_r00(sc_r00), .sc_r01(sc_r01), .sc_r10(sc_r10), .sc_r11(sc_r11),
        .sc_sel(sc_sel), .sc_s(sc_s), .out_valid(out_valid),
        .out_ready(out_ready), .out_pix(out_pix), .busy(busy)
    );

    sc_edge_sequencer #(.W(8), .LAT(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .p00(p00), .p01(p01), .p10(p10), .p11(p11),
        .sc_r00(t_r00), .sc_r01(t_r01), .sc_r10(t_r10), .sc_r11(t_r11),
        .sc_sel(t_sel), .sc_s(sc_s2), .out_valid(out_valid2),
        .out_ready(out_ready2), .out_pix(out_pix2), .busy(busy2)
    );

    assign out_ready2 = 1'b1;
    assign sc_s  = d1;
    assign sc_s2 = g2;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Detector model: a few gate functions of the stream bits.
    function automatic logic fn(input int m, input logic r00, input logic r01,
                                input logic r10, input logic r11, input logic sel);
        case (m)
            1:       return 1'b1;
            2:       return r00;
            3:       return r00 ^ r01;
            4:       return sel;
            5:       return r10 & r11;
            6:       return r00 | r11;
            default: return 1'b0;
        endcase
    endfunction

    always @(negedge clk) begin
        f1 = fn(mode,  sc_r00, sc_r01, sc_r10, sc_r11, sc_sel);
        f2 = fn(mode2, t_r00,  t_r01,  t_r10,  t_r11,  t_sel);
    end

    // Detector latency: 1 clock for dut, 2 clocks for dut2.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        d1  <= f1;
        g1  <= f2;
        g2  <= g1;
    end

    // Scoreboard monitor for dut.
    always @(negedge clk) begin
        if (out_valid && !ov_prev) begin
            if (q.size() == 0) check("unexpected_valid", 1, 0);
            else               check("valid_cycle", cyc, q[0].cyc);
        end
        if (out_valid && out_ready && q.size() > 0) begin
            e1 = q.pop_front();
            check("out_pix", int'(out_pix), e1.pix);
        end
        ov_prev = out_valid;
    end

    // Scoreboard monitor for dut2.
    always @(negedge clk) begin
        if (out_valid2 && !ov2_prev) begin
            if (q2.size() == 0) check("unexpected_valid2", 1, 0);
            else                check("valid_cycle2", cyc, q2[0].cyc);
        end
        if (out_valid2 && out_ready2 && q2.size() > 0) begin
            e2s = q2.pop_front();
            check("out_pix2", int'(out_pix2), e2s.pix);
        end
        ov2_prev = out_valid2;
    end

    task automatic send(input bit which, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] d, input int exp);
        int n;
        n = 0;
        @(posedge clk); #1;
        p00 = a; p01 = b; p10 = c; p11 = d;
        if (which) in_valid2 = 1'b1; else in_valid = 1'b1;
        @(negedge clk);
        while (!(which ? in_ready2 : in_ready) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            check("send_timeout", n, 0);
        end else if (which) begin
            q2.push_back('{exp, cyc + 259});
        end else begin
            q.push_back('{exp, cyc + 258});
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        in_valid2 = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((q.size() > 0 || q2.size() > 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check("drain_timeout", n, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[9];
        int   bad00, n01, n10, n11, badsel, nbusy, bad_hold, bad_rdy, n;

        vecs[0] = '{0,   0,   0,   0,  1, 255};
        vecs[1] = '{0,   0,   0,   0,  2,   0};
        vecs[2] = '{1,   0,   0,   0,  2,   1};
        vecs[3] = '{255, 0,   0,   0,  2, 255};
        vecs[4] = '{128, 9,   9,   9,  2, 128};
        vecs[5] = '{200, 50,  0,   0,  3, 150};
        vecs[6] = '{10,  250, 0,   0,  3, 240};
        vecs[7] = '{0,   0,   90,  33, 5,  33};
        vecs[8] = '{60,  0,   0,   140, 6, 140};

        rst = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0; out_ready = 1'b1;
        p00 = '0; p01 = '0; p10 = '0; p11 = '0;

        // Reset values while held in reset.
        repeat (3) @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_pix", int'(out_pix), 0);
        check("rst_streams", int'({sc_r00, sc_r01, sc_r10, sc_r11, sc_sel}), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_ready_busy", int'({in_ready, busy}), 2);

        // Stream shape, detector output tied 0.
        mode = 0;
        send(1'b0, 8'd100, 8'd0, 8'd255, 8'd37, 0);
        bad00 = 0; n01 = 0; n10 = 0; n11 = 0; badsel = 0; nbusy = 0;
        for (int k = 1; k <= 256; k++) begin
            @(negedge clk);
            if (sc_r00 !== (k <= 100)) bad00++;
            if (sc_r01) n01++;
            if (sc_r10) n10++;
            if (sc_r11) n11++;
            if (sc_sel !== ((k % 2) == 0)) badsel++;
            if (!busy || in_ready) nbusy++;
        end
        check("r00_shape_bad", bad00, 0);
        check("r01_ones", n01, 0);
        check("r10_ones", n10, 255);
        check("r11_ones", n11, 37);
        check("sel_shape_bad", badsel, 0);
        check("run_busy_bad", nbusy, 0);
        @(negedge clk);
        check("drain_streams", int'({sc_r00, sc_r01, sc_r10, sc_r11, sc_sel}), 0);
        wait_drain();

        // Table-driven windows through the LAT=1 instance.
        foreach (vecs[i]) begin
            mode = vecs[i].mode;
            send(1'b0, 8'(vecs[i].a), 8'(vecs[i].b), 8'(vecs[i].c), 8'(vecs[i].d),
                 vecs[i].exp);
            wait_drain();
        end

        // LAT=2 alignment.
        mode2 = 2;
        send(1'b1, 8'd77, 8'd0, 8'd0, 8'd0, 77);
        wait_drain();
        mode2 = 1;
        send(1'b1, 8'd3, 8'd0, 8'd0, 8'd0, 255);
        wait_drain();

        // Backpressure with in_valid toggling while DONE is held.
        @(posedge clk); #1;
        out_ready = 1'b0;
        mode = 2;
        send(1'b0, 8'd200, 8'd0, 8'd0, 8'd0, 200);
        n = 0;
        while (!out_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) check("bp_valid_timeout", n, 0);
        bad_hold = 0; bad_rdy = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            in_valid = ~in_valid;
            p00 = 8'($urandom_range(0, 255));
            @(negedge clk);
            if (out_pix !== 8'd200 || !out_valid) bad_hold++;
            if (in_ready) bad_rdy++;
        end
        check("bp_hold_bad", bad_hold, 0);
        check("bp_in_ready_bad", bad_rdy, 0);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_last_valid", int'(out_valid), 1);
        @(negedge clk);
        check("bp_after_hs", int'({out_valid, in_ready, busy}), 2);
        wait_drain();

        // Asynchronous reset in RUN cycle 50.
        mode = 1;
        send(1'b0, 8'd200, 8'd0, 8'd0, 8'd0, 255);
        repeat (49) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("midrun_rst_state", int'({busy, in_ready, out_valid, sc_r00}), 4'b0100);
        check("midrun_rst_pix", int'(out_pix), 0);
        q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (300) @(negedge clk);
        send(1'b0, 8'd9, 8'd9, 8'd9, 8'd9, 255);
        wait_drain();
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sc_edge_sequencer.md
# sc_edge_sequencer

Sequencer for the stochastic-computing Roberts-cross edge detector. It accepts one 2×2 pixel window per transaction and converts the four binary pixel values into deterministic unary bitstreams. It drives those streams and the scaled-add select into the detector for one full stream period, counts the detector's output ones, and returns the count as a binary edge magnitude through a valid/ready handshake. It sits between the pixel-window fetch logic and the detector datapath, one instance per detector.

## Interface

**Parameters**
- `W`, default 8: pixel width. Stream length is `2^W` cycles.
- `LAT`, default 1: detector latency in clocks, from the `sc_r*`/`sc_sel` inputs to `sc_s`. Valid range is 0..3.

**Ports**
- `clk`, in, 1: the block's single clock. All logic is rising-edge.
- `rst`, in, 1: reset, asynchronous and active-low. The block is held in reset while `rst` is 0.
- `in_valid`, in, 1: a pixel window is offered.
- `in_ready`, out, 1: the block can accept a window.
- `p00`, `p01`, `p10`, `p11`, in, W each: pixel values, unsigned.
- `sc_r00`, `sc_r01`, `sc_r10`, `sc_r11`, out, 1 each: stream bits to the detector.
- `sc_sel`, out, 1: scaled-add select to the detector.
- `sc_s`, in, 1: detector output bit.
- `out_valid`, out, 1: a result is available.
- `out_ready`, in, 1: the consumer accepts the result.
- `out_pix`, out, W: edge magnitude, the saturated ones-count.
- `busy`, out, 1: high in any state other than IDLE.

## Operation

**FSM states:** IDLE, RUN, DRAIN, DONE.

**IDLE**
- `in_ready` = 1.
- On `in_valid & in_ready`: capture `p00`..`p11` into registers, clear the W-bit phase counter `c` and the (W+1)-bit ones-counter `cnt`, then go to RUN.

**RUN**
- Lasts exactly `2^W` cycles. `c` counts 0 .. `2^W-1`.
- `sc_rij = (pij_reg > c)`. The comparison is unsigned, combinational from registers.
  - All four streams share `c`, so they are maximally correlated. XOR of two streams therefore has exactly `|pa - pb|` ones per period.
- `sc_sel = c[0]`.
- When `c == 2^W-1`, go to DRAIN if `LAT > 0`, else to DONE. `c` wraps to 0 and is not reused.

**DRAIN**
- Lasts exactly `LAT` cycles.
- `sc_r*` = 0 and `sc_sel` = 0.

**Counting window**
- A LAT-deep shift register carries a "sample valid" flag that is 1 during RUN.
- `cnt` increments on every cycle where the delayed flag is 1 and `sc_s` is 1.
- Exactly `2^W` samples are examined, so `cnt` ranges over 0..`2^W`.

**DONE**
- `out_valid` = 1.
- `out_pix = min(cnt, 2^W-1)`, registered on DONE entry.
- `out_pix` is held stable until `out_valid & out_ready`, then the FSM goes to IDLE.

**Outputs by state**
- `in_ready` is 0 in RUN, DRAIN and DONE. `in_valid` is ignored there, and captured pixels never change mid-transaction.
- Outside RUN, `sc_r*` and `sc_sel` are 0.

**Reset (asserted at any time, including mid-RUN or DRAIN)**
- Return to IDLE immediately.
- `c`, `cnt`, the delay line and the pixel registers are cleared.
- No result is produced for the aborted window.

## Timing

**Reset values:**
- `in_ready` = 1
- `out_valid` = 0
- `out_pix` = 0
- `sc_r00`..`sc_r11` = 0
- `sc_sel` = 0
- `busy` = 0

**Transaction timeline**, with the input handshake in cycle T:
- RUN occupies T+1 .. T+2^W. The first stream bit, with `c = 0`, appears in T+1.
- Samples are counted in T+1+LAT .. T+2^W+LAT.
- `out_valid` rises in T+2^W+LAT+1. For W=8 and LAT=1 that is T+258.
- `out_valid` falls in the cycle after the cycle where `out_ready` is high. `in_ready` rises in that same cycle.
- If `out_ready` is already high when `out_valid` rises, the FSM is in DONE for exactly 1 cycle.

**Throughput:** one window per `2^W + LAT + 2` cycles at best (259 for the defaults).

**Boundary values:**
- `pij = 0`: stream is all zeros.
- `pij = 2^W-1`: stream is ones for every `c` except the last.

## Test plan

1. **Reset values.** Assert `rst` low asynchronously between clock edges → all outputs reach their reset values immediately. Release → `in_ready` = 1, `busy` = 0.
2. **Stream shape.** Defaults, `p00=100`, `p01=0`, `p10=255`, `p11=37` →
   - `sc_r00` is high exactly in RUN cycles 1–100.
   - `sc_r01` is never high.
   - `sc_r10` is high for 255 cycles.
   - `sc_r11` is high for 37 cycles.
   - `sc_sel` toggles 0,1,0,… starting at 0.
3. **Count extremes.**
   - `sc_s` tied 0 → `out_pix` = 0, with `out_valid` exactly at T+258.
   - `sc_s` tied 1 → `cnt` = 256 and `out_pix` = 255 (saturated).
4. **LAT alignment.** `LAT=2`, with the bench driving `sc_s` as `sc_r00` delayed by 2 cycles and `p00=77` → `out_pix` = 77, with `out_valid` at T+259.
5. **Backpressure.** Hold `out_ready` low for 10 cycles after `out_valid` rises, and toggle `in_valid` meanwhile →
   - `out_pix` stays stable.
   - `in_ready` stays 0 and no capture occurs.
   - The handshake completes on the first cycle `out_ready` is high.
6. **Reset mid-run.** Pull `rst` low in RUN cycle 50, then release and issue a fresh window with `sc_s` tied 1 → no `out_valid` for the aborted window, and the new transaction returns `out_pix` = 255 at the nominal cycle.
